// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-request arbiter.
package sd_arb_pkg;
  localparam int NREQ  = 2;
  localparam int LBA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    XFER     = 2'd2,
    COMPLETE = 2'd3
  } state_t;
endpackage

// File: rtl/sd_req_arbiter.sv
// Two-requester round-robin arbiter in front of the hps_io block-transfer port,
// with per-requester request latches and a transfer timeout.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd5000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [LBA_W-1:0]  req_lba0,
  input  logic [LBA_W-1:0]  req_lba1,
  input  logic              sd_ack,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy
);

  state_t            state, state_n;
  logic [NREQ-1:0]   pending, op_rd, accept, pend_clr;
  logic [LBA_W-1:0]  lba_q [NREQ];
  logic              last, last_n;
  logic [23:0]       cnt, cnt_n;
  logic [LBA_W-1:0]  sd_lba_n;
  logic              sd_rd_n, sd_wr_n, pick, expired;
  logic [NREQ-1:0]   grant_n, done_n, err_n;

  // A pulse is only taken when the requester has nothing outstanding.
  assign accept  = (req_rd | req_wr) & ~pending & ~grant;
  assign expired = (cnt == TIMEOUT - 24'd1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pending <= '0;
      op_rd   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend_clr[i]) begin
          pending[i] <= 1'b0;
        end else if (accept[i]) begin
          pending[i] <= 1'b1;
          op_rd[i]   <= req_rd[i];
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept[0]) lba_q[0] <= req_lba0;
    if (accept[1]) lba_q[1] <= req_lba1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt    <= '0;
      sd_lba <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      grant  <= '0;
      done   <= '0;
      err    <= '0;
    end else begin
      state  <= state_n;
      last   <= last_n;
      cnt    <= cnt_n;
      sd_lba <= sd_lba_n;
      sd_rd  <= sd_rd_n;
      sd_wr  <= sd_wr_n;
      grant  <= grant_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    cnt_n    = cnt;
    sd_lba_n = sd_lba;
    sd_rd_n  = sd_rd;
    sd_wr_n  = sd_wr;
    grant_n  = grant;
    done_n   = '0;
    err_n    = '0;
    pend_clr = '0;
    pick     = (pending == 2'b11) ? ~last : pending[1];
    case (state)
      IDLE: begin
        if (|pending) begin
          state_n        = ISSUE;
          grant_n        = pick ? 2'b10 : 2'b01;
          sd_lba_n       = lba_q[pick];
          sd_rd_n        = op_rd[pick];
          sd_wr_n        = ~op_rd[pick];
          cnt_n          = '0;
          pend_clr[pick] = 1'b1;
        end
      end
      ISSUE, XFER: begin
        cnt_n = cnt + 24'd1;
        // A normal ack fall wins over a timeout hitting in the same cycle.
        if (state == XFER && !sd_ack) begin
          state_n = COMPLETE;
          done_n  = grant;
        end else if (expired) begin
          state_n = IDLE;
          sd_rd_n = 1'b0;
          sd_wr_n = 1'b0;
          grant_n = '0;
          err_n   = grant;
          last_n  = grant[1];
        end else if (state == ISSUE && sd_ack) begin
          state_n = XFER;
          sd_rd_n = 1'b0;
          sd_wr_n = 1'b0;
        end
      end
      COMPLETE: begin
        state_n = IDLE;
        grant_n = '0;
        last_n  = grant[1];
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter with hand-computed expectations per cycle.
module tb_sd_req_arbiter;
  import sd_arb_pkg::*;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_rd, req_wr;
  logic [LBA_W-1:0]  req_lba0, req_lba1;
  logic              sd_ack;
  logic [LBA_W-1:0]  sd_lba;
  logic              sd_rd, sd_wr, busy;
  logic [NREQ-1:0]   grant, done, err;

  int n_checks = 0;
  int n_pass   = 0;

  sd_req_arbiter #(.TIMEOUT(24'd16)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_rd  (req_rd),
    .req_wr  (req_wr),
    .req_lba0(req_lba0),
    .req_lba1(req_lba1),
    .sd_ack  (sd_ack),
    .sd_lba  (sd_lba),
    .sd_rd   (sd_rd),
    .sd_wr   (sd_wr),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Owner currently in ISSUE: ack for one cycle, then drop it and check done.
  task automatic finish_xfer(input string tag, input logic [1:0] owner);
    sd_ack = 1'b1;
    tick();
    check({tag, "_strobe_off"}, {30'd0, sd_rd, sd_wr}, 32'd0);
    sd_ack = 1'b0;
    tick();
    check({tag, "_done"}, done, owner);
    check({tag, "_err"}, err, 2'b00);
    tick();
    check({tag, "_idle"}, {29'd0, busy, grant}, 32'd0);
  endtask

  int early;

  initial begin
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba0 = '0; req_lba1 = '0; sd_ack = 1'b0;
    tick(); tick();
    check("rst_outputs", {sd_rd, sd_wr, grant, done, err, busy}, 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    reset = 1'b0;
    tick();

    // Single read, ack held three cycles.
    req_rd = 2'b01; req_lba0 = 32'h10;
    tick();
    req_rd = 2'b00;
    check("rd_lat1", sd_rd, 1'b0);
    tick();
    check("rd_strobe", {sd_rd, sd_wr}, 2'b10);
    check("rd_lba", sd_lba, 32'h10);
    check("rd_grant", grant, 2'b01);
    check("rd_busy", busy, 1'b1);
    sd_ack = 1'b1;
    tick();
    check("rd_clear", sd_rd, 1'b0);
    tick(); tick();
    check("rd_hold_xfer", {busy, done}, 3'b100);
    sd_ack = 1'b0;
    tick();
    check("rd_done", done, 2'b01);
    tick();
    check("rd_done_pulse", done, 2'b00);
    check("rd_busy_low", busy, 1'b0);

    // Tie after reset: requester 0 first, then 1.
    reset = 1'b1; tick(); reset = 1'b0;
    req_wr = 2'b11; req_lba0 = 32'h100; req_lba1 = 32'h200;
    tick();
    req_wr = 2'b00;
    tick();
    check("tie_grant0", grant, 2'b01);
    check("tie_wr0", {sd_rd, sd_wr}, 2'b01);
    check("tie_lba0", sd_lba, 32'h100);
    sd_ack = 1'b1; tick(); sd_ack = 1'b0; tick();
    check("tie_done0", done, 2'b01);
    tick();
    check("tie_gap", grant, 2'b00);
    tick();
    check("tie_grant1", grant, 2'b10);
    check("tie_wr1", {sd_rd, sd_wr}, 2'b01);
    check("tie_lba1", sd_lba, 32'h200);
    finish_xfer("tie1", 2'b10);

    // Round-robin: 1 was last, so 0 wins the tie.
    req_rd = 2'b11; req_lba0 = 32'h300; req_lba1 = 32'h400;
    tick();
    req_rd = 2'b00;
    tick();
    check("rr_grant0", grant, 2'b01);
    check("rr_lba0", sd_lba, 32'h300);
    finish_xfer("rr0", 2'b01);
    tick();
    check("rr_grant1", grant, 2'b10);
    check("rr_lba1", sd_lba, 32'h400);
    // Request from requester 0 lands during requester 1's COMPLETE cycle.
    sd_ack = 1'b1; tick(); sd_ack = 1'b0; tick();
    check("rr_done1", done, 2'b10);
    req_wr = 2'b01; req_lba0 = 32'h800;
    tick();
    req_wr = 2'b00;
    check("late_idle", busy, 1'b0);
    tick();
    check("late_grant", grant, 2'b01);
    check("late_wr", {sd_rd, sd_wr}, 2'b01);
    check("late_lba", sd_lba, 32'h800);
    finish_xfer("late", 2'b01);

    // Duplicate pulse while granted is ignored.
    req_rd = 2'b01; req_lba0 = 32'h500;
    tick();
    req_rd = 2'b00;
    tick();
    check("dup_grant", grant, 2'b01);
    req_rd = 2'b01; req_lba0 = 32'h99;
    tick();
    req_rd = 2'b00;
    check("dup_lba_hold", sd_lba, 32'h500);
    finish_xfer("dup", 2'b01);
    tick(); tick();
    check("dup_no_second", {29'd0, busy, grant}, 32'd0);
    check("dup_lba_final", sd_lba, 32'h500);

    // Timeout with no ack: err exactly 16 cycles after grant.
    req_rd = 2'b10; req_lba1 = 32'h600;
    tick();
    req_rd = 2'b00;
    tick();
    check("to_grant", grant, 2'b10);
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (err != 2'b00 || done != 2'b00 || grant != 2'b10) early++;
    end
    check("to_no_early", early, 0);
    tick();
    check("to_err", err, 2'b10);
    check("to_done", done, 2'b00);
    check("to_strobe", {sd_rd, grant}, 3'b000);
    tick();
    check("to_err_pulse", {busy, err}, 3'b000);

    // Reset while in XFER.
    req_rd = 2'b01; req_lba0 = 32'h700;
    tick();
    req_rd = 2'b00;
    tick();
    sd_ack = 1'b1;
    tick();
    check("rx_xfer", {busy, sd_rd, grant}, 4'b1001);
    reset = 1'b1;
    tick();
    check("rx_zero", {sd_rd, sd_wr, grant, done, err, busy}, 32'd0);
    check("rx_lba", sd_lba, 32'd0);
    reset = 1'b0; sd_ack = 1'b0;
    tick(); tick();
    check("rx_quiet", {grant, done, err, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd5000000, is the clk_sys cycles allowed from sd_rd/sd_wr assertion to sd_ack falling before abort.
REQ-002 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_rd  input  2  one-cycle read-request pulse, bit i = requester i (0 = ZPU drive emulation, 1 = cart/save loader).
REQ-005 req_wr  input  2  one-cycle write-request pulse per requester.
REQ-006 req_lba0 / req_lba1  input  32 each  sector address, sampled with that requester's pulse.
REQ-007 sd_ack  input  1  HPS transfer-active acknowledge.
REQ-008 sd_lba  output  32  sector address of the active transfer.
REQ-009 sd_rd / sd_wr  output  1 each  block read/write strobe to hps_io.
REQ-010 grant  output  2  one-hot owner of the transfer and of sector-buffer port B; 0 when idle.
REQ-011 done  output  2  one-cycle pulse to the owner on normal completion.
REQ-012 err  output  2  one-cycle pulse to the owner on timeout abort.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Each requester has a pending bit, op bit and 32-bit LBA latch; a pulse sets pending, latches LBA and op (read wins if req_rd[i] and req_wr[i] coincide).
REQ-015 A pulse from requester i while it is pending or granted is ignored; latches are unchanged.
REQ-016 FSM states are IDLE, ISSUE, XFER and COMPLETE.
REQ-017 In IDLE with one pending bit, that requester is granted; with both pending, the one not served last is granted (round-robin).
REQ-018 On grant: sd_lba, grant and sd_rd or sd_wr are registered; the pending bit clears; the state becomes ISSUE.
REQ-019 Latency from a request pulse in cycle t on an idle arbiter to sd_rd/sd_wr high is 2 clocks.
REQ-020 In ISSUE, sd_rd/sd_wr stay high until sd_ack is sampled 1; they then clear on the next edge and the state becomes XFER.
REQ-021 In XFER, sd_ack sampled 0 moves the state to COMPLETE.
REQ-022 COMPLETE lasts one cycle: done[owner] pulses, grant clears, last-served records the owner, and the state returns to IDLE.
REQ-023 A 24-bit timeout counter clears on grant and increments every cycle in ISSUE/XFER.
REQ-024 When the counter reaches TIMEOUT-1: sd_rd/sd_wr/grant clear, err[owner] pulses, last-served updates, and the state returns to IDLE.
REQ-025 sd_lba holds its value until the next grant.
REQ-026 A request pulse arriving during COMPLETE or abort from the other requester is latched and may be granted in the very next IDLE cycle.
REQ-027 done and err are never asserted in the same cycle, and never to a non-owner.

Reset
REQ-028 Reset forces IDLE, clears pending/op bits, sets sd_rd=sd_wr=0, grant=0, done=err=0, busy=0, sd_lba=0 and counter=0.
REQ-029 Reset sets last-served=1 so requester 0 wins the first tie.
REQ-030 Reset mid-transfer drops the transfer without a done/err pulse.

Structure
REQ-031 Package sd_arb_pkg holds the state enum, NREQ=2 and the LBA width constant 32.
REQ-032 The block is a single module with no sub-modules; the top level uses grant[1] to select the sector-buffer port-B address, data and write-enable.

Verification
REQ-033 Single read: req_rd=01, req_lba0=0x00000010 -> sd_rd high 2 clocks later with sd_lba=0x10 and grant=01; sd_ack high 3 cycles -> sd_rd low; sd_ack low -> done=01 for 1 cycle and busy low.
REQ-034 Tie: req_wr=11 in the same cycle after reset -> requester 0 is served first with sd_wr; requester 1 is granted in the IDLE cycle after done=01.
REQ-035 Round-robin: after requester 1 is served last, simultaneous req_rd=11 -> requester 0 is granted first.
REQ-036 Timeout: TIMEOUT=16, sd_ack never asserted -> err[owner] pulses exactly 16 cycles after grant, sd_rd low, and no done pulse.
REQ-037 Duplicate: a req_rd[0] pulse while grant=01 with req_lba0=0x99 -> no second transfer, and sd_lba stays at the original value.
REQ-038 Reset asserted in XFER -> next cycle shows IDLE outputs (all zero), and no done/err pulse.
